perf_counter_bank: RTL
======================

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 Parameter NUM_EVT, default 6, number of independent event channels (1..16).
REQ-002 Parameter CNT_W, default 32, width of every counter (8..32).
REQ-003 Parameter SATURATE, default 0; 0 = counters wrap, 1 = counters saturate at all-ones.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 evt  input  NUM_EVT  per-channel event strobe; bit i high = one event on channel i this cycle.
REQ-007 halt  input  1  processor halted this cycle; triggers freeze.
REQ-008 clear  input  1  zero all counters and overflow flags, return to RUN.
REQ-009 rd_req  input  1  readout request for one counter.
REQ-010 rd_sel  input  5  counter index; 0..NUM_EVT-1 = event channels, NUM_EVT = cycle counter.
REQ-011 rd_valid  output  1  rd_data valid this cycle.
REQ-012 rd_data  output  CNT_W  selected counter value.
REQ-013 rd_err  output  1  with rd_valid: rd_sel was out of range.
REQ-014 cycle_cnt  output  CNT_W  live cycle counter.
REQ-015 frozen  output  1  high while in FROZEN state.
REQ-016 ovf  output  NUM_EVT  sticky per-channel overflow/saturation flag.

Function
REQ-017 Two states, RUN and FROZEN; reset enters RUN.
REQ-018 RUN -> FROZEN on the cycle after halt is sampled high; FROZEN -> RUN only on clear.
REQ-019 In RUN, each cycle cycle_cnt increments by 1 and counter i increments by 1 when evt[i] is high.
REQ-020 Events and the cycle tick in the cycle halt is sampled high are counted; nothing is counted in FROZEN.
REQ-021 halt sampled while FROZEN has no effect.
REQ-022 SATURATE=0: counter at all-ones plus event becomes 0 and sets ovf[i] in the same edge.
REQ-023 SATURATE=1: counter at all-ones holds all-ones; an event at all-ones sets ovf[i].
REQ-024 Cycle counter follows the same wrap/saturate rule; it has no ovf bit.
REQ-025 ovf bits are sticky until clear or rst.
REQ-026 clear (any state): next edge sets all counters, cycle_cnt and ovf to 0 and state to RUN; events in the clear cycle are discarded.
REQ-027 clear and halt sampled together: clear wins; state RUN, counters 0.
REQ-028 Readout latency is one cycle: rd_req at edge N gives rd_valid=1 and rd_data at edge N+1, held for exactly one cycle.
REQ-029 rd_data returns the counter value before any update at edge N (pre-increment, pre-clear).
REQ-030 rd_sel > NUM_EVT: rd_valid=1, rd_err=1, rd_data=0.
REQ-031 Back-to-back rd_req on consecutive cycles is supported, one response per request, in order.
REQ-032 Readout never stalls counting and never changes state.
REQ-033 When rd_valid=0, rd_data=0 and rd_err=0.

Reset
REQ-034 rst high at an edge: counters, cycle_cnt, ovf, rd_valid, rd_err, rd_data = 0; frozen = 0; state RUN.
REQ-035 rst overrides clear, halt and rd_req in the same cycle; a read pending at reset is dropped.
REQ-036 Reset mid-FROZEN returns to RUN with zero counters on the next edge.

Verification
REQ-037 NUM_EVT=6, CNT_W=32: reset, evt[0] high for 10 cycles, evt[3] for 4, then halt -> frozen=1 next cycle; reads give ch0=10, ch3=4, cycle_cnt = cycles since reset including halt cycle.
REQ-038 CNT_W=8, SATURATE=0: 256 events on ch1 -> ch1=0, ovf[1]=1; 1 more -> ch1=1, ovf[1] still 1.
REQ-039 CNT_W=8, SATURATE=1: 300 events on ch2 -> ch2=0xFF, ovf[2]=1; other channels unaffected.
REQ-040 rd_req with rd_sel=2 in same cycle as evt[2] and clear, ch2=7 -> next cycle rd_data=7; following read ch2=0.
REQ-041 Back-to-back reads sel=0,1,6,9 (NUM_EVT=6) -> four consecutive rd_valid pulses; last has rd_err=1, rd_data=0; sel=6 returns cycle counter.
REQ-042 halt and clear together while FROZEN -> frozen=0, all counters 0; rst asserted with rd_req pending -> rd_valid=0 next cycle.

Source files
------------

// File: rtl/perf_counter_bank.sv
// Bank of event counters plus a free-running cycle counter, frozen by halt
// and cleared by clear; single-cycle-latency readout of any counter.

module perf_counter_lane #(
  parameter int CNT_W    = 32,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_ovf
);
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (i_inc) begin
      if (&r_cnt) begin
        r_ovf <= 1'b1;
        if (SATURATE == 0) r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_cnt = r_cnt;
  assign o_ovf = r_ovf;
endmodule

module perf_counter_bank #(
  parameter int NUM_EVT  = 6,
  parameter int CNT_W    = 32,
  parameter int SATURATE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               halt,
  input  logic               clear,
  input  logic               rd_req,
  input  logic [4:0]         rd_sel,
  output logic               rd_valid,
  output logic [CNT_W-1:0]   rd_data,
  output logic               rd_err,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic               frozen,
  output logic [NUM_EVT-1:0] ovf
);
  typedef enum logic {RUN, FROZEN} state_t;

  state_t                          r_state;
  logic   [CNT_W-1:0]              r_cyc;
  logic                            r_rd_valid;
  logic                            r_rd_err;
  logic   [CNT_W-1:0]              r_rd_data;
  logic                            w_run;
  logic   [NUM_EVT-1:0][CNT_W-1:0] w_cnt;
  logic   [CNT_W-1:0]              w_sel_val;
  logic                            w_sel_bad;

  assign w_run = (r_state == RUN);

  for (genvar g = 0; g < NUM_EVT; g++) begin : g_lane
    perf_counter_lane #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .i_clr (clear),
      .i_inc (w_run & evt[g]),
      .o_cnt (w_cnt[g]),
      .o_ovf (ovf[g])
    );
  end

  // Index NUM_EVT selects the cycle counter; anything above it is an error.
  always_comb begin
    w_sel_val = '0;
    w_sel_bad = (rd_sel > 5'(NUM_EVT));
    if (rd_sel == 5'(NUM_EVT)) w_sel_val = r_cyc;
    for (int i = 0; i < NUM_EVT; i++)
      if (rd_sel == 5'(i)) w_sel_val = w_cnt[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_cyc      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      if (clear)               r_state <= RUN;
      else if (w_run && halt)  r_state <= FROZEN;

      if (clear) begin
        r_cyc <= '0;
      end else if (w_run) begin
        if (&r_cyc) begin
          if (SATURATE == 0) r_cyc <= '0;
        end else begin
          r_cyc <= r_cyc + CNT_W'(1);
        end
      end

      // Sampled before this edge's update, so reads see pre-increment/pre-clear values.
      r_rd_valid <= rd_req;
      r_rd_err   <= rd_req & w_sel_bad;
      r_rd_data  <= (rd_req && !w_sel_bad) ? w_sel_val : '0;
    end
  end

  assign rd_valid  = r_rd_valid;
  assign rd_err    = r_rd_err;
  assign rd_data   = r_rd_data;
  assign cycle_cnt = r_cyc;
  assign frozen    = (r_state == FROZEN);
endmodule
